mhd_flip_gen: RTL
=================

# mhd_flip_gen

Sequential stimulus generator for the Hamming-distance miter flow. It accepts a reference word and a target distance, then flips exactly that many distinct bit positions, chosen pseudo-randomly, to produce a perturbed word. It returns the pair (original, perturbed) together with the expected miter verdict (`distance > MHD`). It sits upstream of the width-34 / MHD-4 miter as its pair generator and golden-model source for approximate-circuit error checking.

## Interface
- `BIT`, 34, word width.
- `MHD`, 4, miter threshold used for `out_expect`.
- `DIST_W`, 6, distance field width; must satisfy 2^DIST_W > BIT.
- `LFSR_SEED`, 6'h2D, nonzero seed for the position LFSR.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  generator idle and able to accept.
- `in_word`  in  BIT  reference word a.
- `in_dist`  in  DIST_W  requested Hamming distance.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_a`  out  BIT  captured reference word.
- `out_b`  out  BIT  perturbed word, a ^ mask.
- `out_dist`  out  DIST_W  effective distance after clamping.
- `out_expect`  out  1  `out_dist > MHD`; the expected miter output f.

## Operation
- States: IDLE, FLIP, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, capture `in_word` into `a_q`, set `dist_q = min(in_dist, BIT)`, clear `mask` and `cnt`, and go to FLIP.
- FLIP: each cycle, check `cnt == dist_q` first. If equal, go to DONE and do not flip. Otherwise `pos = lfsr - 1` (range 0..62). If `pos < BIT && !mask[pos]`, set `mask[pos]` and increment `cnt`. Otherwise reject the position; no other change.
- DONE: `out_valid`=1; `out_b = a_q ^ mask`. On `out_ready`, go to IDLE.
- LFSR: 6-bit Fibonacci, polynomial x^6+x^5+1, maximal length 63. It advances every cycle in every state and is loaded with `LFSR_SEED` on reset.
- Termination: all 63 nonzero states are visited, so every unset position in 0..33 is hit within 63 cycles. Each flip completes in at most 63 FLIP cycles.
- Invariant at DONE: popcount(`out_a ^ out_b`) == `out_dist`.
- `in_dist` > BIT is clamped to BIT. It is not an error.

## Timing
- Reset values:
  - state=IDLE, `in_ready`=1, `out_valid`=0.
  - `out_a`, `out_b` = 0; `out_dist`=0; `out_expect`=0.
  - `mask`=0, `cnt`=0, `lfsr`=`LFSR_SEED`.
- All outputs are registered or decoded directly from state. There is no combinational path from inputs to outputs.
- Accept at edge T: FLIP is active from T+1. With `dist_q`=0, FLIP at T+1 detects completion and `out_valid` rises at T+2.
- Minimum latency: T+2+d, where d = `dist_q`, reached when every LFSR draw is accepted.
- Maximum latency: T+2+63·d.
- `in_ready` is 0 in FLIP and DONE. A request is never accepted while a result is pending.
- While `out_valid && !out_ready`, all `out_*` signals hold stable.
- Return to IDLE at edge U (`out_valid && out_ready`): the earliest next accept is at edge U+1.
- `rst` asserted mid-FLIP or mid-DONE: the transaction is dropped immediately and no result is emitted.
- `out_a` reflects `a_q` from capture onward; it is meaningful only while `out_valid`=1.

## Structure
- Package `mhd_pkg`:
  - Constants `BIT`, `MHD`, `DIST_W`.
  - Enum `mhd_gen_state_t` {IDLE, FLIP, DONE}.
  - LFSR tap constant and default seed.
- Sub-module `mhd_lfsr6`: free-running 6-bit LFSR with async reset to seed. Reused by future miter stimulus blocks.
- Top-level holds the FSM, the mask register, the counter and the handshakes. Expected size is about 150–200 lines.

## Test plan
- `in_word`=34'h0, `in_dist`=4:
  - `out_b` has exactly 4 ones, `out_dist`=4, `out_expect`=0, `out_a`=0.
- `in_word`=34'h2AAAAAAAA, `in_dist`=34:
  - `out_b`=34'h155555555 (all bits inverted), `out_expect`=1.
  - Latency stays within the bound.
- `in_dist`=0, `in_word`=34'h3FFFFFFFF:
  - `out_valid` rises exactly 2 cycles after accept.
  - `out_b`=`in_word`, `out_expect`=0.
- `in_dist`=40:
  - `out_dist`=34 and `out_b` = ~`in_word`.
  - `in_dist`=5 gives `out_expect`=1; `in_dist`=4 gives `out_expect`=0.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE while `in_valid`=1.
  - `out_*` stay stable and `in_ready` stays 0.
  - After `out_ready`, the next request is accepted one cycle later.
- Assert `rst` mid-FLIP (`in_dist`=20, after 5 cycles):
  - Outputs return to reset values with no `out_valid` pulse.
  - A new request with `in_dist`=3 then completes correctly.

Source files
------------

// File: rtl/mhd_pkg.sv
// Shared constants and types for the Hamming-distance miter stimulus blocks.
package mhd_pkg;

  localparam int BIT    = 34;
  localparam int MHD    = 4;
  localparam int DIST_W = 6;

  // x^6 + x^5 + 1: feedback is the XOR of the two top bits.
  localparam logic [5:0] LFSR_TAPS = 6'b110000;
  localparam logic [5:0] LFSR_SEED = 6'h2D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLIP = 2'd1,
    DONE = 2'd2
  } mhd_gen_state_t;

endpackage

// File: rtl/mhd_lfsr6.sv
// Free-running 6-bit Fibonacci LFSR, period 63, async reset to seed.
module mhd_lfsr6 #(
  parameter logic [5:0] SEED = mhd_pkg::LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst,
  output logic [5:0] q
);
  import mhd_pkg::*;

  logic fb;
  assign fb = ^(q & LFSR_TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= SEED;
    else     q <= {q[4:0], fb};
  end

endmodule

// File: rtl/mhd_flip_gen.sv
// Flips exactly dist distinct LFSR-chosen bits of a reference word and
// returns (a, a^mask, dist, dist > MHD) as a golden pair for the miter.
module mhd_flip_gen #(
  parameter int         BIT       = mhd_pkg::BIT,
  parameter int         MHD       = mhd_pkg::MHD,
  parameter int         DIST_W    = mhd_pkg::DIST_W,
  parameter logic [5:0] LFSR_SEED = mhd_pkg::LFSR_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BIT-1:0]    in_word,
  input  logic [DIST_W-1:0] in_dist,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BIT-1:0]    out_a,
  output logic [BIT-1:0]    out_b,
  output logic [DIST_W-1:0] out_dist,
  output logic              out_expect
);
  import mhd_pkg::*;

  mhd_gen_state_t    state;
  logic [BIT-1:0]    a_q;
  logic [BIT-1:0]    mask;
  logic [DIST_W-1:0] dist_q;
  logic [DIST_W-1:0] cnt;
  logic [DIST_W-1:0] dist_clamp;
  logic [5:0]        lfsr;
  logic [5:0]        pos;
  logic [BIT-1:0]    sel;
  logic              hit;

  mhd_lfsr6 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  // LFSR never reads zero, so pos spans 0..62; anything >= BIT is a rejected draw.
  assign pos        = lfsr - 6'd1;
  assign sel        = (int'(pos) < BIT) ? (BIT'(1'b1) << pos) : '0;
  assign hit        = |(sel & ~mask);
  assign dist_clamp = (in_dist > DIST_W'(BIT)) ? DIST_W'(BIT) : in_dist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      mask   <= '0;
      dist_q <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q    <= in_word;
          dist_q <= dist_clamp;
          mask   <= '0;
          cnt    <= '0;
          state  <= FLIP;
        end
        // Completion is tested before drawing, so dist=0 spends one FLIP cycle.
        FLIP: if (cnt == dist_q) begin
          state <= DONE;
        end else if (hit) begin
          mask <= mask | sel;
          cnt  <= cnt + DIST_W'(1);
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_a      = a_q;
  assign out_b      = a_q ^ mask;
  assign out_dist   = dist_q;
  assign out_expect = (dist_q > DIST_W'(MHD));

endmodule
